// File: rtl/unsigned_16by8_seq_div_pkg.sv
// Shared definitions for the unsigned 16-by-8 sequential restoring divider.
// Holds the default operand widths, the FSM state type and a result record
// that both the design and its environment can use.
package unsigned_16by8_seq_div_pkg;

    localparam int DIV_DW = 16;  // dividend / quotient width
    localparam int DIV_VW = 8;   // divisor / remainder width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [DIV_DW-1:0] quotient;
        logic [DIV_VW-1:0] remainder;
        logic              div_by_zero;
    } div_result_t;

endpackage

// File: rtl/unsigned_16by8_seq_div_restore_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   prem_i     restored partial remainder from the previous step (always < divisor)
//   dvd_bit_i  next dividend bit shifted in at the bottom
//   divisor_i  divisor
//   prem_o     partial remainder after this step
//   q_bit_o    quotient bit produced by this step
module unsigned_16by8_seq_div_restore_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] prem_i,
    input  logic          dvd_bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] prem_o,
    output logic          q_bit_o
);

    // Trial value is one bit wider than the divisor so the shift cannot overflow.
    logic [VW:0] trial;
    logic        ge;

    assign trial   = {prem_i, dvd_bit_i};
    assign ge      = (trial >= {1'b0, divisor_i});
    assign q_bit_o = ge;
    // When ge, trial - divisor < divisor, so the low VW bits of the modular
    // difference are the exact result; when !ge, trial < divisor has a zero MSB.
    assign prem_o  = ge ? (trial[VW-1:0] - divisor_i) : trial[VW-1:0];

endmodule

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential restoring divider: unsigned DW-bit dividend by VW-bit divisor,
// one quotient bit per clock. A zero divisor finishes immediately with an
// all-ones quotient, zero remainder and div_by_zero set.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         operand handshake (dividend, divisor)
//   out_valid / out_ready       result handshake (quotient, remainder, div_by_zero)
//   dbg_state_o                 current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and the
// result outputs are held stable while out_valid && !out_ready. The two sides
// are never ready in the same state, so a new operand can be accepted at the
// earliest on the edge after the result handshake.
module unsigned_16by8_seq_div
    import unsigned_16by8_seq_div_pkg::*;
#(
    parameter  int DW = DIV_DW,
    parameter  int VW = DIV_VW,
    localparam int CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output div_state_e    dbg_state_o
);

    div_state_e    state_q, state_d;
    // Dividend shift register: dividend bits leave at the top while quotient
    // bits enter at the bottom, so after DW steps it holds the quotient.
    logic [DW-1:0] dvd_q, dvd_d;
    // Restored partial remainder; it is always < divisor, so VW bits suffice.
    // The VW+1-bit shifted trial value is formed inside the step.
    logic [VW-1:0] prem_q, prem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [VW-1:0] step_prem;
    logic          step_qbit;

    unsigned_16by8_seq_div_restore_step #(
        .VW(VW)
    ) u_step (
        .prem_i    (prem_q),
        .dvd_bit_i (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .prem_o    (step_prem),
        .q_bit_o   (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend;
                    prem_d = '0;
                    dvs_d  = divisor;
                    cnt_d  = CW'(DW);
                    dbz_d  = 1'b0;
                    if (divisor != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        dvd_d   = '1;
                        dbz_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                dvd_d  = {dvd_q[DW-2:0], step_qbit};
                prem_d = step_prem;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = dvd_q;
    assign remainder   = prem_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Self-checking bench for unsigned_16by8_seq_div: directed scenarios plus a
// randomized run scored against a plain-arithmetic reference model.
module tb_unsigned_16by8_seq_div;
    import unsigned_16by8_seq_div_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    div_state_e  dbg_state;

    int tests_run;
    int tests_failed;

    logic [24:0] exp_q[$];  // {div_by_zero, quotient, remainder}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    unsigned_16by8_seq_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [15:0] r;
        if (b == 8'd0) return {1'b1, 16'hFFFF, 8'h00};
        q = a / {8'd0, b};
        r = a % {8'd0, b};
        return {1'b0, q, r[7:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one division from IDLE through the result handshake and reports
    // what was observed. hold = cycles to keep out_ready low after out_valid.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int hold,
                           output logic [15:0] q, output logic [7:0] r, output logic z,
                           output int lat, output int busy_rdy, output int unstable,
                           output logic post_ok, output logic timeout);
        int guard;
        timeout  = 1'b0;
        busy_rdy = 0;
        unstable = 0;
        lat      = -1;
        post_ok  = 1'b0;
        q = '0; r = '0; z = 1'b0;
        out_ready = (hold == 0);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            timeout  = 1'b1;
            in_valid = 1'b0;
            return;
        end
        step();  // accept edge
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy++;
            step();
            lat++;
        end
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        for (int i = 0; i < hold; i++) begin
            if (in_ready) busy_rdy++;
            if (!out_valid) unstable++;
            if ({quotient, remainder, div_by_zero} !== {q, r, z}) unstable++;
            step();
        end
        if (in_ready) busy_rdy++;
        if (!out_valid) unstable++;
        out_ready = 1'b1;
        step();  // result handshake edge
        out_ready = 1'b0;
        post_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        step(); step();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (quotient !== 16'd0 || remainder !== 8'd0) begin
            tests_failed++; $display("FAIL reset_result got q=%0d r=%0d want 0/0", quotient, remainder);
        end
        tests_run++;
        if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] q; logic [7:0] r; logic z; int lat, br, us; logic pok, to;
        run_div(16'd1000, 8'd7, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_timeout got timeout want result"); end
        tests_run++;
        if (q !== 16'd142 || r !== 8'd6 || z !== 1'b0) begin
            tests_failed++; $display("FAIL basic_1000_7 got q=%0d r=%0d z=%b want 142/6/0", q, r, z);
        end
        tests_run++;
        if (lat !== 16) begin tests_failed++; $display("FAIL basic_latency got %0d want 16", lat); end
        tests_run++;
        if (pok !== 1'b1) begin tests_failed++; $display("FAIL basic_one_cycle_valid got post_ok=%b want 1", pok); end
        tests_run++;
        if (br !== 0) begin tests_failed++; $display("FAIL basic_in_ready_busy got %0d high cycles want 0", br); end
    endtask

    task automatic test_max_operands();
        logic [15:0] q; logic [7:0] r; logic z; int lat, br, us; logic pok, to;
        run_div(16'd65535, 8'd255, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'd257 || r !== 8'd0) begin
            tests_failed++; $display("FAIL max_65535_255 got q=%0d r=%0d to=%b want 257/0", q, r, to);
        end
        tests_run++;
        if (br !== 0) begin tests_failed++; $display("FAIL max_in_ready_busy got %0d want 0", br); end
        run_div(16'd65535, 8'd1, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'd65535 || r !== 8'd0) begin
            tests_failed++; $display("FAIL max_65535_1 got q=%0d r=%0d to=%b want 65535/0", q, r, to);
        end
        tests_run++;
        if (br !== 0) begin tests_failed++; $display("FAIL max1_in_ready_busy got %0d want 0", br); end
    endtask

    task automatic test_div_zero();
        logic [15:0] q; logic [7:0] r; logic z; int lat, br, us; logic pok, to;
        run_div(16'd5, 8'd0, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'hFFFF || r !== 8'd0 || z !== 1'b1) begin
            tests_failed++; $display("FAIL dbz_5_0 got q=%h r=%0d z=%b to=%b want FFFF/0/1", q, r, z, to);
        end
        tests_run++;
        if (lat !== 0) begin tests_failed++; $display("FAIL dbz_latency got %0d want 0", lat); end
        tests_run++;
        if (pok !== 1'b1) begin tests_failed++; $display("FAIL dbz_post got post_ok=%b want 1", pok); end
        run_div(16'd200, 8'd201, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'd0 || r !== 8'd200 || z !== 1'b0) begin
            tests_failed++; $display("FAIL dbz_next_200_201 got q=%0d r=%0d z=%b want 0/200/0", q, r, z);
        end
        tests_run++;
        if (lat !== 16) begin tests_failed++; $display("FAIL dbz_next_latency got %0d want 16", lat); end
    endtask

    task automatic test_backpressure();
        logic [15:0] q; logic [7:0] r; logic z; int lat, br, us; logic pok, to;
        run_div(16'd50000, 8'd3, 5, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'd16666 || r !== 8'd2 || z !== 1'b0) begin
            tests_failed++; $display("FAIL bp_50000_3 got q=%0d r=%0d z=%b want 16666/2/0", q, r, z);
        end
        tests_run++;
        if (us !== 0) begin tests_failed++; $display("FAIL bp_hold_stable got %0d changes want 0", us); end
        tests_run++;
        if (br !== 0) begin tests_failed++; $display("FAIL bp_in_ready_busy got %0d want 0", br); end
        tests_run++;
        if (pok !== 1'b1) begin tests_failed++; $display("FAIL bp_return_idle got post_ok=%b want 1", pok); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] q; logic [7:0] r; logic z; int lat, br, us; logic pok, to;
        int stale;
        out_ready = 1'b1;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        step();  // accept edge (block is idle here)
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        tests_run++;
        if (dbg_state !== ST_RUN) begin tests_failed++; $display("FAIL midrst_running got state %0d want RUN", dbg_state); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd0 ||
            remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs got v=%b rdy=%b q=%0d r=%0d z=%b want 0/1/0/0/0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        step(); step();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) stale++;
            step();
        end
        tests_run++;
        if (stale !== 0) begin tests_failed++; $display("FAIL midrst_stale got %0d valid cycles want 0", stale); end
        run_div(16'd300, 8'd17, 0, q, r, z, lat, br, us, pok, to);
        tests_run++;
        if (to || q !== 16'd17 || r !== 8'd11 || z !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_300_17 got q=%0d r=%0d z=%b want 17/11/0", q, r, z);
        end
    endtask

    task automatic test_random();
        int n_acc, n_res, cycles;
        logic acc, hs;
        logic [24:0] exp;
        n_acc = 0; n_res = 0; cycles = 0;
        exp_q.delete();
        while (n_acc < 1500 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       divisor = 8'd0;
                1:       divisor = 8'd1;
                2:       divisor = 8'd255;
                default: divisor = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       dividend = 16'd0;
                1:       dividend = 16'd65535;
                default: dividend = 16'($urandom);
            endcase
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                n_res++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_unexpected got q=%0d r=%0d z=%b want no result", quotient, remainder, div_by_zero);
                end else begin
                    exp = exp_q.pop_front();
                    if ({div_by_zero, quotient, remainder} !== exp) begin
                        tests_failed++;
                        $display("FAIL rand_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                                 quotient, remainder, div_by_zero, exp[23:8], exp[7:0], exp[24]);
                    end
                end
            end
            if (acc) begin
                n_acc++;
                exp_q.push_back(model(dividend, divisor));
            end
            step();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 100) begin
            if (out_valid) begin
                n_res++;
                exp = exp_q.pop_front();
                tests_run++;
                if ({div_by_zero, quotient, remainder} !== exp) begin
                    tests_failed++;
                    $display("FAIL rand_drain got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                             quotient, remainder, div_by_zero, exp[23:8], exp[7:0], exp[24]);
                end
            end
            step();
            cycles++;
        end
        out_ready = 1'b0;
        step();
        tests_run++;
        if (n_res !== n_acc || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_count got %0d results want %0d accepted", n_res, n_acc);
        end
        tests_run++;
        if (n_acc < 1500) begin
            tests_failed++; $display("FAIL rand_progress got %0d accepted want 1500", n_acc);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_max_operands();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
